// File: rtl/hqc_encap_pkg.sv
// Shared HQC encapsulation constants: per-parameter-set code dimensions,
// their address widths, and the state encoding used by the encapsulation stages.
package hqc_encap_pkg;

    localparam int HQC128_N1_BYTES     = 46;
    localparam int HQC128_MULTIPLICITY = 3;
    localparam int HQC128_N_WORDS      = HQC128_N1_BYTES * HQC128_MULTIPLICITY;

    localparam int HQC192_N1_BYTES     = 56;
    localparam int HQC192_MULTIPLICITY = 5;
    localparam int HQC192_N_WORDS      = HQC192_N1_BYTES * HQC192_MULTIPLICITY;

    localparam int HQC256_N1_BYTES     = 90;
    localparam int HQC256_MULTIPLICITY = 5;
    localparam int HQC256_N_WORDS      = HQC256_N1_BYTES * HQC256_MULTIPLICITY;

    localparam int HQC128_LOG_N1_BYTES = $clog2(HQC128_N1_BYTES);
    localparam int HQC128_LOG_N_WORDS  = $clog2(HQC128_N_WORDS);
    localparam int HQC192_LOG_N1_BYTES = $clog2(HQC192_N1_BYTES);
    localparam int HQC192_LOG_N_WORDS  = $clog2(HQC192_N_WORDS);
    localparam int HQC256_LOG_N1_BYTES = $clog2(HQC256_N1_BYTES);
    localparam int HQC256_LOG_N_WORDS  = $clog2(HQC256_N_WORDS);

    localparam int WORD_BITS = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/concat_cdw_add_addr_gen.sv
// Read-address generator: walks w over all output words while i steps once
// every MULTIPLICITY words, so that w = i*MULTIPLICITY + j holds throughout.
module concat_cdw_add_addr_gen #(
    parameter int N1_BYTES     = 56,
    parameter int MULTIPLICITY = 5,
    parameter int N_WORDS      = 280,
    parameter int LOG_N1_BYTES = 6,
    parameter int LOG_N_WORDS  = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    advance,
    output logic [LOG_N1_BYTES-1:0] i,
    output logic [LOG_N_WORDS-1:0]  w,
    output logic                    last
);

    localparam int LOG_MULT = (MULTIPLICITY > 1) ? $clog2(MULTIPLICITY) : 1;
    localparam logic [LOG_MULT-1:0]    J_MAX = LOG_MULT'(MULTIPLICITY - 1);
    localparam logic [LOG_N_WORDS-1:0] W_MAX = LOG_N_WORDS'(N_WORDS - 1);

    logic [LOG_MULT-1:0] j;

    assign last = (w == W_MAX);

    // Wrapping on the last word leaves the counters at zero for the next run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i <= '0;
            j <= '0;
            w <= '0;
        end else if (clear || (advance && last)) begin
            i <= '0;
            j <= '0;
            w <= '0;
        end else if (advance) begin
            w <= w + LOG_N_WORDS'(1);
            if (j == J_MAX) begin
                j <= '0;
                i <= i + LOG_N1_BYTES'(1);
            end else begin
                j <= j + LOG_MULT'(1);
            end
        end
    end

endmodule

// File: rtl/concat_cdw_add.sv
// Expands each RM codeword word by repetition and XORs it with s*r2+e to form v.
// Optional macro CONCAT_CDW_ADD_OUT_REG_EN adds one output register stage on the write port.
module concat_cdw_add
    import hqc_encap_pkg::*;
#(
    parameter string parameter_set = "hqc192",
    localparam int N1_BYTES     = (parameter_set == "hqc128") ? HQC128_N1_BYTES :
                                  (parameter_set == "hqc256") ? HQC256_N1_BYTES : HQC192_N1_BYTES,
    localparam int MULTIPLICITY = (parameter_set == "hqc128") ? HQC128_MULTIPLICITY :
                                  (parameter_set == "hqc256") ? HQC256_MULTIPLICITY : HQC192_MULTIPLICITY,
    localparam int N_WORDS      = N1_BYTES * MULTIPLICITY,
    localparam int LOG_N1_BYTES = $clog2(N1_BYTES),
    localparam int LOG_N_WORDS  = $clog2(N_WORDS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    cdw_rd_en,
    output logic [LOG_N1_BYTES-1:0] cdw_rd_addr,
    input  logic [WORD_BITS-1:0]    cdw_rd_data,
    output logic                    sr2e_rd_en,
    output logic [LOG_N_WORDS-1:0]  sr2e_rd_addr,
    input  logic [WORD_BITS-1:0]    sr2e_rd_data,
    output logic                    v_wr_en,
    output logic [LOG_N_WORDS-1:0]  v_wr_addr,
    output logic [WORD_BITS-1:0]    v_wr_data,
    output logic                    busy,
    output logic                    done
);

    state_t state_reg, state_next;

    logic                    run;
    logic                    rd_last;
    logic [LOG_N1_BYTES-1:0] i_cnt;
    logic [LOG_N_WORDS-1:0]  w_cnt;

    logic                    wr_en_reg;
    logic [LOG_N_WORDS-1:0]  wr_addr_reg;
    logic                    wr_last_reg;
    logic [WORD_BITS-1:0]    xor_data;
    logic                    final_last;

    assign run = (state_reg == RUN);

    concat_cdw_add_addr_gen #(
        .N1_BYTES     (N1_BYTES),
        .MULTIPLICITY (MULTIPLICITY),
        .N_WORDS      (N_WORDS),
        .LOG_N1_BYTES (LOG_N1_BYTES),
        .LOG_N_WORDS  (LOG_N_WORDS)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (!run),
        .advance (run),
        .i       (i_cnt),
        .w       (w_cnt),
        .last    (rd_last)
    );

    // Write stage lines up with the read data returned one cycle after the strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_last_reg <= 1'b0;
        end else begin
            wr_en_reg   <= run;
            wr_addr_reg <= run ? w_cnt : '0;
            wr_last_reg <= run && rd_last;
        end
    end

    assign xor_data = wr_en_reg ? (cdw_rd_data ^ sr2e_rd_data) : '0;

`ifdef CONCAT_CDW_ADD_OUT_REG_EN
    logic                   out_en_reg;
    logic [LOG_N_WORDS-1:0] out_addr_reg;
    logic [WORD_BITS-1:0]   out_data_reg;
    logic                   out_last_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_en_reg   <= 1'b0;
            out_addr_reg <= '0;
            out_data_reg <= '0;
            out_last_reg <= 1'b0;
        end else begin
            out_en_reg   <= wr_en_reg;
            out_addr_reg <= wr_addr_reg;
            out_data_reg <= xor_data;
            out_last_reg <= wr_last_reg;
        end
    end

    assign v_wr_en    = out_en_reg;
    assign v_wr_addr  = out_addr_reg;
    assign v_wr_data  = out_data_reg;
    assign final_last = out_last_reg;
`else
    assign v_wr_en    = wr_en_reg;
    assign v_wr_addr  = wr_addr_reg;
    assign v_wr_data  = xor_data;
    assign final_last = wr_last_reg;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FLUSH holds until the final write has left the pipeline, whatever its depth.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (rd_last) state_next = FLUSH;
            FLUSH:   if (final_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cdw_rd_en    = 1'b0;
        sr2e_rd_en   = 1'b0;
        cdw_rd_addr  = '0;
        sr2e_rd_addr = '0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_reg)
            RUN: begin
                cdw_rd_en    = 1'b1;
                sr2e_rd_en   = 1'b1;
                cdw_rd_addr  = i_cnt;
                sr2e_rd_addr = w_cnt;
                busy         = 1'b1;
            end
            FLUSH:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_concat_cdw_add.sv
// Self-checking bench for concat_cdw_add: one instance per parameter set, each
// backed by a registered-read memory model holding the scenario's data pattern.
module tb_concat_cdw_add;

`ifdef CONCAT_CDW_ADD_OUT_REG_EN
    localparam int XL = 1;
`else
    localparam int XL = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] start_v = 3'b000;

    always #5 clk = ~clk;

    // hqc128 instance
    logic         cren0, sren0, wen0, busy0, done0;
    logic [5:0]   ca0;
    logic [7:0]   sa0, wa0;
    logic [127:0] cd0, sd0, wd0;
    // hqc192 instance
    logic         cren1, sren1, wen1, busy1, done1;
    logic [5:0]   ca1;
    logic [8:0]   sa1, wa1;
    logic [127:0] cd1, sd1, wd1;
    // hqc256 instance
    logic         cren2, sren2, wen2, busy2, done2;
    logic [6:0]   ca2;
    logic [8:0]   sa2, wa2;
    logic [127:0] cd2, sd2, wd2;

    concat_cdw_add #(.parameter_set("hqc128")) u_dut0 (
        .clk(clk), .rst(rst_n), .start(start_v[0]),
        .cdw_rd_en(cren0), .cdw_rd_addr(ca0), .cdw_rd_data(cd0),
        .sr2e_rd_en(sren0), .sr2e_rd_addr(sa0), .sr2e_rd_data(sd0),
        .v_wr_en(wen0), .v_wr_addr(wa0), .v_wr_data(wd0),
        .busy(busy0), .done(done0));

    concat_cdw_add #(.parameter_set("hqc192")) u_dut1 (
        .clk(clk), .rst(rst_n), .start(start_v[1]),
        .cdw_rd_en(cren1), .cdw_rd_addr(ca1), .cdw_rd_data(cd1),
        .sr2e_rd_en(sren1), .sr2e_rd_addr(sa1), .sr2e_rd_data(sd1),
        .v_wr_en(wen1), .v_wr_addr(wa1), .v_wr_data(wd1),
        .busy(busy1), .done(done1));

    concat_cdw_add #(.parameter_set("hqc256")) u_dut2 (
        .clk(clk), .rst(rst_n), .start(start_v[2]),
        .cdw_rd_en(cren2), .cdw_rd_addr(ca2), .cdw_rd_data(cd2),
        .sr2e_rd_en(sren2), .sr2e_rd_addr(sa2), .sr2e_rd_data(sd2),
        .v_wr_en(wen2), .v_wr_addr(wa2), .v_wr_data(wd2),
        .busy(busy2), .done(done2));

    // Memory models with registered read
    always @(posedge clk) begin
        if (cren0) cd0 <= {16{8'(ca0)}};
        if (sren0) sd0 <= '0;
        if (cren1) cd1 <= '0;
        if (sren1) sd1 <= {4{32'(sa1)}};
        if (cren2) cd2 <= '1;
        if (sren2) sd2 <= '1;
    end

    logic [2:0]          ob_ren, ob_sren, ob_wen, ob_busy, ob_done;
    logic [2:0][31:0]    ob_ca, ob_sa, ob_wa;
    logic [2:0][127:0]   ob_wd;

    assign ob_ren  = {cren2, cren1, cren0};
    assign ob_sren = {sren2, sren1, sren0};
    assign ob_wen  = {wen2, wen1, wen0};
    assign ob_busy = {busy2, busy1, busy0};
    assign ob_done = {done2, done1, done0};
    assign ob_ca   = {32'(ca2), 32'(ca1), 32'(ca0)};
    assign ob_sa   = {32'(sa2), 32'(sa1), 32'(sa0)};
    assign ob_wa   = {32'(wa2), 32'(wa1), 32'(wa0)};
    assign ob_wd   = {wd2, wd1, wd0};

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
    } exp_t;

    typedef struct {
        int sel;
        int nw;
        int mult;
        int p1;
        int p2;
        int exp_done;
    } scn_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cur_rel = 0;
    int   cur_sel = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h want %h (set %0d, cycle %0d)", name, act, expv, cur_sel, cur_rel);
        end
    endtask

    // Expected v word from the test-plan data patterns.
    function automatic logic [127:0] vexp(input int s, input int w);
        logic [7:0] b;
        b = 8'(w / 3);
        case (s)
            0:       return {16{b}};
            1:       return {4{32'(w)}};
            default: return '0;
        endcase
    endfunction

    task automatic check_idle(input logic [1:0] s, input string tag);
        chk({tag, " rd_en"},   128'(ob_ren[s]),  128'(0));
        chk({tag, " sr2e_en"}, 128'(ob_sren[s]), 128'(0));
        chk({tag, " cdw_addr"},128'(ob_ca[s]),   128'(0));
        chk({tag, " sr2e_addr"},128'(ob_sa[s]),  128'(0));
        chk({tag, " wr_en"},   128'(ob_wen[s]),  128'(0));
        chk({tag, " wr_addr"}, 128'(ob_wa[s]),   128'(0));
        chk({tag, " wr_data"}, ob_wd[s],         128'(0));
        chk({tag, " busy"},    128'(ob_busy[s]), 128'(0));
        chk({tag, " done"},    128'(ob_done[s]), 128'(0));
    endtask

    task automatic run_scn(input scn_t sc, input int rst_at);
        logic [1:0] s;
        int   reads, writes, dones, last_rel;
        exp_t e;
        s = 2'(sc.sel);
        cur_sel = sc.sel;
        reads = 0; writes = 0; dones = 0;
        sb.delete();
        last_rel = sc.nw + 2 + XL + 4;
        @(negedge clk);
        start_v = 3'(1 << sc.sel);
        @(negedge clk);
        for (int r = 1; r <= last_rel; r++) begin
            cur_rel = r;
            start_v = (r == sc.p1 || r == sc.p2) ? 3'(1 << sc.sel) : 3'b000;
            if (r == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_idle(s, "mid-run reset");
                @(negedge clk);
                rst_n = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check_idle(s, "after reset");
                end
                $display("[TB] set %0d: reset at cycle %0d after %0d writes", sc.sel, r, writes);
                return;
            end
            chk("cdw_rd_en",  128'(ob_ren[s]),  128'(r >= 1 && r <= sc.nw));
            chk("sr2e_rd_en", 128'(ob_sren[s]), 128'(r >= 1 && r <= sc.nw));
            if (ob_ren[s]) begin
                chk("cdw_rd_addr",  128'(ob_ca[s]), 128'(reads / sc.mult));
                chk("sr2e_rd_addr", 128'(ob_sa[s]), 128'(reads));
                sb.push_back('{addr: 32'(reads), data: vexp(sc.sel, reads)});
                reads++;
            end
            chk("v_wr_en", 128'(ob_wen[s]), 128'(r >= 2 + XL && r <= sc.nw + 1 + XL));
            if (ob_wen[s]) begin
                if (sb.size() == 0) begin
                    chk("write without read", 128'(1), 128'(0));
                end else begin
                    e = sb.pop_front();
                    chk("v_wr_addr", 128'(ob_wa[s]), 128'(e.addr));
                    chk("v_wr_data", ob_wd[s], e.data);
                end
                writes++;
            end
            chk("done", 128'(ob_done[s]), 128'(r == sc.exp_done));
            if (ob_done[s]) dones++;
            chk("busy", 128'(ob_busy[s]), 128'(r >= 1 && r <= sc.nw + 1 + XL));
            @(negedge clk);
        end
        start_v = 3'b000;
        chk("read count",  128'(reads),   128'(sc.nw));
        chk("write count", 128'(writes),  128'(sc.nw));
        chk("done count",  128'(dones),   128'(1));
        chk("scoreboard empty", 128'(sb.size()), 128'(0));
        $display("[TB] set %0d: %0d reads, %0d writes, %0d done pulses", sc.sel, reads, writes, dones);
    endtask

    scn_t scn [4];

    initial begin
        scn[0] = '{sel: 0, nw: 138, mult: 3, p1: 0,  p2: 0,   exp_done: 140 + XL};
        scn[1] = '{sel: 1, nw: 280, mult: 5, p1: 0,  p2: 0,   exp_done: 282 + XL};
        scn[2] = '{sel: 2, nw: 450, mult: 5, p1: 0,  p2: 0,   exp_done: 452 + XL};
        scn[3] = '{sel: 0, nw: 138, mult: 3, p1: 10, p2: 140, exp_done: 140 + XL};

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            cur_sel = k;
            check_idle(2'(k), "reset state");
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int n = 0; n < 4; n++) begin
            run_scn(scn[n], 0);
        end

        // Mid-run reset, then a clean full run on the same instance.
        run_scn(scn[0], 52);
        run_scn(scn[0], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/concat_cdw_add.md
# concat_cdw_add

Encapsulation stage directly downstream of the concatenated RS/RM encoder. It reads the 128-bit Reed–Muller codeword words produced per RS symbol and expands each one to its N2 length by repetition. It XORs every expanded word with the matching word of the precomputed s·r2 + e vector and writes the resulting ciphertext component v to the output memory. It sustains one 128-bit word per cycle with a fixed, data-independent schedule.

## Interface
Parameters:
- parameter_set, "hqc192": selects "hqc128" / "hqc192" / "hqc256".
- N1_BYTES, 46/56/90 by set: RS codeword length in symbols, one 128-bit RM word per symbol.
- MULTIPLICITY, 3/5/5 by set: repetitions of each RM word (N2/128).
- N_WORDS, N1_BYTES*MULTIPLICITY: v length in 128-bit words (138/280/450).
- LOG_N1_BYTES, `CLOG2(N1_BYTES).
- LOG_N_WORDS, `CLOG2(N_WORDS).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request; accepted only in IDLE.
- cdw_rd_en  out  1  codeword read strobe.
- cdw_rd_addr  out  LOG_N1_BYTES  RS symbol index.
- cdw_rd_data  in  128  codeword word; valid one cycle after strobe.
- sr2e_rd_en  out  1  s·r2+e read strobe.
- sr2e_rd_addr  out  LOG_N_WORDS  word index.
- sr2e_rd_data  in  128  vector word; valid one cycle after strobe.
- v_wr_en  out  1  output write strobe.
- v_wr_addr  out  LOG_N_WORDS  output word index.
- v_wr_data  out  128  cdw word XOR sr2e word.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE → RUN on start. RUN → FLUSH after the read for w = N_WORDS−1 is issued. FLUSH → DONE after the last write. DONE → IDLE unconditionally.
- Counters: i (0..N1_BYTES−1), j (0..MULTIPLICITY−1), w (0..N_WORDS−1). Each RUN cycle w increments and j increments. When j wraps to 0, i increments. Invariant: w = i*MULTIPLICITY + j.
- In each RUN cycle, both reads are issued: cdw_rd_addr = i, sr2e_rd_addr = w. The codeword is re-read on every repetition; no codeword word is held locally.
- In the next cycle: v_wr_data = cdw_rd_data ^ sr2e_rd_data, and v_wr_addr = w delayed by one cycle.
- start while busy or in DONE is ignored.
- Reset, including mid-run: all state and counters clear to IDLE. Every output is 0: strobes, addresses, v_wr_data, busy, done. No partial write completes after reset.
- All addresses are unsigned. No address ever exceeds N_WORDS−1 or N1_BYTES−1.

## Timing
- start sampled high at edge 0.
- Read strobes are high in cycles 1..N_WORDS.
- v_wr_en is high in cycles 2..N_WORDS+1, one write per cycle, addresses strictly 0,1,2,…
- done pulses in cycle N_WORDS+2. busy is high in cycles 1..N_WORDS+1.
- Total latency: hqc128 140, hqc192 282, hqc256 452 cycles.
- Back-to-back: the earliest accepted start is in the cycle after done (IDLE).

## Configuration
- CONCAT_CDW_ADD_OUT_REG_EN defined: one extra register stage on v_wr_en, v_wr_addr and v_wr_data. Writes occur in cycles 3..N_WORDS+2, done in N_WORDS+3, and busy extends one cycle to match.
- Undefined: timing exactly as above. Read-side timing is identical in both cases.

## Structure
- Shared package hqc_encap_pkg holds per-set constants N1_BYTES, MULTIPLICITY, N_WORDS and their log widths, plus the FSM state enum.
- One sub-module: concat_cdw_add_addr_gen, containing the i/j/w counters, the wrap logic and the last-word flag.

## Test plan
- hqc128; cdw word k = {16{k[7:0]}}, sr2e all zero → 138 writes; v[w] = {16{(w/3)[7:0]}}; last address 137; done at cycle 140.
- hqc192; cdw all zero, sr2e word w = {4{w[31:0]}} → v equals sr2e exactly; 280 writes; done at cycle 282.
- hqc256; both memories all ones → 450 writes of zero; final cdw_rd_addr 89 and sr2e_rd_addr 449 are never exceeded; done at cycle 452.
- start pulsed again at cycles 10 and 140 of an hqc128 run → ignored; exactly one done; no address restart.
- Reset asserted at cycle 52 of a run → all outputs 0 in the same cycle, FSM in IDLE; a fresh start then gives a full, correct 138-word run.
- CONCAT_CDW_ADD_OUT_REG_EN defined, hqc128 → first write at cycle 3, done at cycle 141, data identical to the first scenario.
